sd_spi_initiator: RTL and testbench



---
 rtl/sd_spi_initiator_pkg.sv | 18 +
 rtl/sd_spi_initiator_if.sv | 17 +
 rtl/sd_spi_initiator_clk_div.sv | 23 ++
 rtl/sd_spi_initiator.sv | 116 +++++++++++
 tb/tb_sd_spi_initiator.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_spi_initiator_pkg.sv
// Shared constants for the SD-card SPI initiator: FSM encodings, idle byte,
// default dividers and a small sizing helper.
package sd_spi_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;

    localparam int DEF_SLOW_DIV = 63;
    localparam int DEF_FAST_DIV = 2;
    localparam int DEF_LED_HOLD = 2**20;

    function automatic int max_div(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/sd_spi_initiator_if.sv
// CPU-side byte handshake between the SD controller (master) and the SPI
// initiator (slave).
interface sd_spi_initiator_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       slow;
    logic       cs_assert;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    modport master (output tx_data, tx_valid, slow, cs_assert,
                    input  tx_ready, rx_data, rx_valid, busy);
    modport slave  (input  tx_data, tx_valid, slow, cs_assert,
                    output tx_ready, rx_data, rx_valid, busy);
endinterface

// File: rtl/sd_spi_initiator_clk_div.sv
// SCLK half-period counter: reloads DIV-1 on i_load, counts down, and
// flags the last cycle of the phase on o_tc.
module spi_clk_div #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_div,
    output logic         o_tc
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)            r_cnt <= '0;
        else if (i_load)         r_cnt <= i_div - ONE;
        else if (r_cnt != '0)    r_cnt <= r_cnt - ONE;
    end

    assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/sd_spi_initiator.sv
// Byte-level SPI mode-0 initiator for the SD slot: MSB-first shift out,
// MISO sampled at the end of each SCLK high phase, CS and activity LED.
module sd_spi_initiator
    import sd_spi_pkg::*;
#(
    parameter int SLOW_DIV = DEF_SLOW_DIV,
    parameter int FAST_DIV = DEF_FAST_DIV,
    parameter int LED_HOLD = DEF_LED_HOLD
) (
    input  logic               clk,
    input  logic               n_reset,
    sd_spi_initiator_if.slave  host,
    output logic               sdCS,
    output logic               sdSCLK,
    output logic               sdMOSI,
    input  logic               sdMISO,
    output logic               driveLED
);
    localparam int DW = $clog2(max_div(SLOW_DIV, FAST_DIV) + 1);
    localparam int HW = $clog2(LED_HOLD + 1);
    localparam logic [DW-1:0] SLOW_L   = DW'(SLOW_DIV);
    localparam logic [DW-1:0] FAST_L   = DW'(FAST_DIV);
    localparam logic [HW-1:0] HOLD_L   = HW'(LED_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic [1:0]    r_state;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx, r_rx, r_rx_data;
    logic          r_cs, r_sclk, r_mosi;
    logic [HW-1:0] r_hold;

    logic          w_ready, w_accept, w_tc, w_load, w_shifting;
    logic [DW-1:0] w_div_sel, w_div_ld;

    assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept   = w_ready & host.tx_valid;
    assign w_shifting = (r_state == ST_LOW) || (r_state == ST_HIGH);
    assign w_div_sel  = host.slow ? SLOW_L : FAST_L;
    assign w_div_ld   = w_accept ? w_div_sel : r_div;
    assign w_load     = w_accept | (w_shifting & w_tc);

    spi_clk_div #(.W(DW)) u_div (
        .clk     (clk),
        .n_reset (n_reset),
        .i_load  (w_load),
        .i_div   (w_div_ld),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= ST_IDLE;
            r_div     <= FAST_L;
            r_bit     <= '0;
            r_tx      <= SD_IDLE_BYTE;
            r_rx      <= SD_IDLE_BYTE;
            r_rx_data <= SD_IDLE_BYTE;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b1;
        end else begin
            case (r_state)
                ST_LOW: if (w_tc) begin
                    r_state <= ST_HIGH;
                    r_sclk  <= 1'b1;
                end
                ST_HIGH: if (w_tc) begin
                    r_rx   <= {r_rx[6:0], sdMISO};
                    r_sclk <= 1'b0;
                    if (r_bit == '0) begin
                        r_state   <= ST_DONE;
                        r_rx_data <= {r_rx[6:0], sdMISO};
                        r_mosi    <= 1'b1;
                    end else begin
                        r_state <= ST_LOW;
                        r_bit   <= r_bit - 3'd1;
                        r_mosi  <= r_tx[7];
                        r_tx    <= {r_tx[6:0], 1'b1};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Accept in DONE overrides the return to IDLE: back-to-back bytes.
            if (w_accept) begin
                r_state <= ST_LOW;
                r_div   <= w_div_sel;
                r_bit   <= 3'd7;
                r_mosi  <= host.tx_data[7];
                r_tx    <= {host.tx_data[6:0], 1'b1};
            end
        end
    end

    // CS is only allowed to move between bytes, never inside a burst.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            r_cs <= 1'b1;
        else if ((r_state == ST_IDLE) || ((r_state == ST_DONE) && !w_accept))
            r_cs <= ~host.cs_assert;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)               r_hold <= '0;
        else if (r_state == ST_DONE) r_hold <= HOLD_L;
        else if (r_hold != '0)      r_hold <= r_hold - HOLD_ONE;
    end

    assign host.tx_ready = w_ready;
    assign host.busy     = (r_state != ST_IDLE);
    assign host.rx_valid = (r_state == ST_DONE);
    assign host.rx_data  = r_rx_data;
    assign sdCS          = r_cs;
    assign sdSCLK        = r_sclk;
    assign sdMOSI        = r_mosi;
    assign driveLED      = host.busy | (r_hold != '0);
endmodule

// File: tb/tb_sd_spi_initiator.sv
// Bench for sd_spi_initiator: vector table of single-byte transfers plus
// back-to-back, mid-byte reset and LED hold sequences; rx bytes scoreboarded.
module tb_sd_spi_initiator;
    localparam int SDIV = 63;
    localparam int FDIV = 2;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic sdCS, sdSCLK, sdMOSI, sdMISO, driveLED;
    logic loop = 1'b1;
    logic miso_k = 1'b1;

    sd_spi_initiator_if host();

    sd_spi_initiator #(.SLOW_DIV(SDIV), .FAST_DIV(FDIV), .LED_HOLD(HOLD)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .host     (host),
        .sdCS     (sdCS),
        .sdSCLK   (sdSCLK),
        .sdMOSI   (sdMOSI),
        .sdMISO   (sdMISO),
        .driveLED (driveLED)
    );

    always #5 clk = ~clk;
    assign sdMISO = loop ? sdMOSI : miso_k;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor state, updated exactly at negedge; the stimulus side reads it at negedge+1.
    logic [7:0] exp_q[$];
    int rises = 0, cs_lo_rises = 0, rxv_cnt = 0;
    int hi_run = 0, lo_run = 0;
    int hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
    logic prev_sclk = 1'b0;
    logic [7:0] mosi_byte = '0;
    bit led_trk = 1'b0;
    int led_cnt = 0, led_len = -1;

    always @(negedge clk) begin
        if (sdSCLK && !prev_sclk) begin
            rises++;
            if (!sdCS) cs_lo_rises++;
            mosi_byte = {mosi_byte[6:0], sdMOSI};
            if (lo_run > 0) begin
                if (lo_run < lo_min) lo_min = lo_run;
                if (lo_run > lo_max) lo_max = lo_run;
            end
            hi_run = 1;
        end else if (!sdSCLK && prev_sclk) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            lo_run = 1;
        end else if (sdSCLK) begin
            hi_run++;
        end else if (lo_run > 0) begin
            lo_run++;
        end
        prev_sclk = sdSCLK;

        if (host.rx_valid) begin
            rxv_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rx_spurious: rx_valid with rx_data=0x%02h, no byte expected", host.rx_data);
            end else begin
                chk("rx_data", int'(host.rx_data), int'(exp_q.pop_front()));
            end
            led_trk = 1'b1;
            led_cnt = 0;
        end else if (led_trk) begin
            if (!driveLED) begin
                led_trk = 1'b0;
                led_len = led_cnt;
            end else if (!host.busy) begin
                led_cnt++;
            end
        end
    end

    task automatic reset_stats();
        rises = 0; cs_lo_rises = 0; mosi_byte = '0;
        hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0; lo_run = 0;
    endtask

    task automatic xfer(input string tag, input logic [7:0] tx, input logic sl, input logic lp,
                        input logic mk, input logic [7:0] exp_rx, input int exp_lat,
                        input int div, input bit tog);
        int lat, cs_lo;
        bit got;
        loop = lp; miso_k = mk;
        for (int i = 0; i < 200 && !host.tx_ready; i++) tick();
        chk({tag, "_ready"}, int'(host.tx_ready), 1);
        reset_stats();
        host.tx_data = tx; host.slow = sl; host.tx_valid = 1'b1;
        exp_q.push_back(exp_rx);
        tick();
        host.tx_valid = 1'b0;
        got = 1'b0; lat = -1; cs_lo = 0;
        for (int i = 0; i < 3000; i++) begin
            if (host.rx_valid) begin got = 1'b1; lat = i + 1; break; end
            if (tog && i == 10) begin host.cs_assert = 1'b1; host.slow = ~sl; end
            if (tog && !sdCS) cs_lo++;
            tick();
        end
        if (!got) exp_q.delete();
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_mosi_done"}, int'(sdMOSI), 1);
        if (tog) begin
            chk({tag, "_cs_held_cycles_low"}, cs_lo, 0);
            chk({tag, "_cs_in_done"}, int'(sdCS), 1);
        end
        tick();
        chk({tag, "_rx_valid_width"}, int'(host.rx_valid), 0);
        chk({tag, "_rx_data_held"}, int'(host.rx_data), int'(exp_rx));
        if (tog) chk({tag, "_cs_after_done"}, int'(sdCS), 0);
        chk({tag, "_sclk_rises"}, rises, 8);
        chk({tag, "_hi_min"}, hi_min, div);
        chk({tag, "_hi_max"}, hi_max, div);
        chk({tag, "_lo_min"}, lo_min, div);
        chk({tag, "_lo_max"}, lo_max, div);
        chk({tag, "_mosi_byte"}, int'(mosi_byte), int'(tx));
        if (tog) begin host.cs_assert = 1'b0; host.slow = sl; tick(); tick(); end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       sl, lp, mk;
        logic [7:0] exp_rx;
        int         lat, div;
        bit         tog;
    } vec_t;

    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc, gap, span, nrx, rx0;
        bit done;
        host.tx_data = 8'h00; host.tx_valid = 1'b0; host.slow = 1'b0; host.cs_assert = 1'b0;

        vt[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 16*FDIV+1, FDIV, 1'b0};
        vt[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 16*SDIV+1, SDIV, 1'b0};
        vt[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 16*FDIV+1, FDIV, 1'b0};
        vt[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 16*FDIV+1, FDIV, 1'b0};
        vt[4] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'hFF, 16*FDIV+1, FDIV, 1'b1};

        // Reset values
        tick(); tick();
        chk("rst_sdCS", int'(sdCS), 1);
        chk("rst_sdSCLK", int'(sdSCLK), 0);
        chk("rst_sdMOSI", int'(sdMOSI), 1);
        chk("rst_rx_data", int'(host.rx_data), 8'hFF);
        chk("rst_rx_valid", int'(host.rx_valid), 0);
        chk("rst_busy", int'(host.busy), 0);
        chk("rst_tx_ready", int'(host.tx_ready), 1);
        chk("rst_driveLED", int'(driveLED), 0);
        n_reset = 1'b1;
        tick(); tick();

        for (int v = 0; v < 5; v++)
            xfer($sformatf("vec%0d", v), vt[v].tx, vt[v].sl, vt[v].lp, vt[v].mk,
                 vt[v].exp_rx, vt[v].lat, vt[v].div, vt[v].tog);

        // Ten 0xFF dummy bytes, CS deasserted, accepted back-to-back in DONE
        loop = 1'b1; host.cs_assert = 1'b0; host.tx_data = 8'hFF; host.slow = 1'b0;
        for (int i = 0; i < 50 && !host.tx_ready; i++) tick();
        tick();
        reset_stats();
        acc = 0; gap = 0; span = 0; nrx = 0;
        host.tx_valid = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if (host.tx_valid && host.tx_ready) begin acc++; exp_q.push_back(8'hFF); end
            tick();
            span++;
            if (acc == 10) host.tx_valid = 1'b0;
            if (host.rx_valid) nrx++;
            if (!host.busy) gap++;
            if (nrx == 10) break;
        end
        host.tx_valid = 1'b0;
        chk("b2b_accepts", acc, 10);
        chk("b2b_rx_count", nrx, 10);
        chk("b2b_span", span, 10 * (16*FDIV+1));
        chk("b2b_idle_gap", gap, 0);
        chk("b2b_sclk_rises", rises, 80);
        chk("b2b_cs_low_rises", cs_lo_rises, 0);
        tick(); tick();

        // Reset after three bits with the card selected
        loop = 1'b1; host.cs_assert = 1'b1;
        tick(); tick();
        chk("mrst_cs_selected", int'(sdCS), 0);
        reset_stats();
        host.tx_data = 8'hC3; host.slow = 1'b0; host.tx_valid = 1'b1;
        tick();
        host.tx_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rises >= 3) begin done = 1'b1; break; end
            tick();
        end
        chk("mrst_three_bits", int'(done), 1);
        tick(); tick(); tick();
        rx0 = rxv_cnt;
        n_reset = 1'b0; host.tx_valid = 1'b1;
        #1;
        chk("mrst_sdCS", int'(sdCS), 1);
        chk("mrst_sdSCLK", int'(sdSCLK), 0);
        chk("mrst_sdMOSI", int'(sdMOSI), 1);
        chk("mrst_busy", int'(host.busy), 0);
        chk("mrst_rx_data", int'(host.rx_data), 8'hFF);
        tick(); tick(); tick();
        chk("mrst_tx_valid_ignored", int'(host.busy), 0);
        n_reset = 1'b1; host.tx_valid = 1'b0; host.cs_assert = 1'b0;
        tick(); tick(); tick();
        chk("mrst_no_rx_valid", rxv_cnt - rx0, 0);
        chk("mrst_rx_data_after", int'(host.rx_data), 8'hFF);
        xfer("post_rst", 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 16*FDIV+1, FDIV, 1'b0);

        // LED hold and re-light
        for (int i = 0; i < 100 && driveLED; i++) tick();
        led_len = -1;
        xfer("led", 8'h81, 1'b0, 1'b1, 1'b0, 8'h81, 16*FDIV+1, FDIV, 1'b0);
        for (int i = 0; i < 100 && driveLED; i++) tick();
        chk("led_hold_len", led_len, HOLD);
        chk("led_off", int'(driveLED), 0);
        tick();
        host.tx_data = 8'h99; host.slow = 1'b0; host.tx_valid = 1'b1;
        exp_q.push_back(8'h99);
        tick();
        host.tx_valid = 1'b0;
        chk("led_relight", int'(driveLED), 1);
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (host.rx_valid) begin done = 1'b1; break; end
            tick();
        end
        chk("led_xfer_done", int'(done), 1);
        tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
